// File: rtl/prng_word_fifo.sv
// PRNG word sink: repetition health test, 64-bit FIFO, 32-bit valid/ready drain.
// A stuck source sets a sticky fault and flushes everything buffered behind it.
module prng_word_fifo #(
    parameter int DEPTH     = 4,
    parameter int REP_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              prng_in,
    input  logic                     prng_en,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clear_fault,
    output logic                     fault,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic {LO, HI} phase_t;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    phase_t        phase;
    logic [RW-1:0] rep_cnt, rep_next;
    logic          last_valid;
    logic [63:0]   last_word, head;
    logic          sample, violate, push_req, full, push, hs, pop;

    assign full     = (level == FULL_LVL);
    assign sample   = prng_en & ~clear_fault & ~fault;

    always_comb begin
        rep_next = RW'(1);
        if (last_valid && prng_in == last_word)
            rep_next = (rep_cnt == REP_MAX) ? REP_MAX : rep_cnt + RW'(1);
    end

    assign violate  = sample & (rep_next == REP_MAX);
    assign push_req = sample & ~violate;
    assign push     = push_req & ~full;
    assign hs       = out_valid & out_ready;
    assign pop      = hs & (phase == HI);

    assign out_valid = (level != '0);
    assign head      = mem[rd_ptr];
    assign out_data  = !out_valid ? 32'd0 : (phase == HI) ? head[63:32] : head[31:0];

    // Storage carries no reset: it is only visible through out_valid gating.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= prng_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            phase      <= LO;
            fault      <= 1'b0;
            rep_cnt    <= '0;
            last_valid <= 1'b0;
            last_word  <= '0;
            drop_cnt   <= '0;
        end else begin
            if (clear_fault) begin
                fault      <= 1'b0;
                rep_cnt    <= '0;
                last_valid <= 1'b0;
            end else if (sample) begin
                rep_cnt    <= rep_next;
                last_word  <= prng_in;
                last_valid <= 1'b1;
                if (violate) fault <= 1'b1;
            end

            // The violating sample flushes the queue and beats any pop this cycle.
            if (violate) begin
                rd_ptr <= wr_ptr;
                level  <= '0;
                phase  <= LO;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push) - LW'(pop);
                if (hs) phase <= (phase == LO) ? HI : LO;
            end

            if (push_req && full && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule
